// File: rtl/syscall_pkg.sv
// syscall_pkg
// Shared constants and types for the syscall engine: the $v0 selector codes
// the unit understands, the encodings placed on out_kind, and the engine FSM
// state encoding.
package syscall_pkg;

    // $v0 selector values
    localparam int unsigned SYS_PRINT_INT  = 1;
    localparam int unsigned SYS_EXIT       = 10;
    localparam int unsigned SYS_PRINT_CHAR = 11;
    localparam int unsigned SYS_EXIT2      = 17;

    // Print request kind carried with each FIFO entry; 2 and 3 are reserved
    typedef enum logic [1:0] {
        KIND_INT  = 2'd0,
        KIND_CHAR = 2'd1
    } out_kind_e;

    // Engine state: RUN retires instructions, DRAIN empties the print FIFO
    // after an exit, HALT is terminal until reset
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/syscall_fifo.sv
// syscall_fifo
// Small synchronous FIFO holding queued print requests.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (empties the FIFO)
//   push        write push_data at the tail (ignored when full)
//   push_data   entry to enqueue
//   pop         drop the head entry (ignored when empty)
//   full        DEPTH entries held
//   empty       no entries held
//   head        oldest entry; only meaningful while empty is low
module syscall_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: an entry is only observed after being written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// syscall_unit
// Syscall engine sitting at MEM/WB. Retiring SYSCALLs are decoded by $v0:
// print requests are queued for a console over valid/ready, exits drain the
// queue and then freeze the unit. Also keeps saturating cycle/retire counters.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   syscall_en     control marks the retiring instruction as a syscall
//   instr          retiring instruction word (funct field checked)
//   instr_valid    an instruction retires this cycle unless stalled
//   v0, a0         syscall selector and argument
//   stall          hold the retiring instruction (combinational)
//   out_valid      print FIFO head valid
//   out_ready      consumer accepts the head
//   out_kind       0 print int, 1 print char
//   out_data       head payload
//   halted         program exited and queue drained
//   exit_code      0 for exit, a0 for exit-with-code
//   bad_syscall    sticky flag for an unsupported selector
//   cycle_count    cycles spent before halting (saturating)
//   instr_count    instructions retired (saturating)
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int          DATA_W        = 32,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          CNT_W         = 48,
    parameter logic [5:0]  FUNCT_SYSCALL = 6'h0C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_en,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    output logic [DATA_W-1:0] exit_code,
    output logic              bad_syscall,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int ENTRY_W = 2 + DATA_W;

    state_e             state;
    state_e             state_next;
    logic               in_run;
    logic               sc_hit;
    logic               is_print_int;
    logic               is_print_char;
    logic               is_exit;
    logic               is_exit2;
    logic               is_print;
    logic               is_exit_any;
    logic               retire;
    logic               push;
    logic               pop;
    logic               exit_retire;
    logic               bad_retire;
    logic               fifo_full;
    logic               fifo_empty;
    out_kind_e          push_kind;
    logic [DATA_W-1:0]  push_payload;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               unused_instr_bits;

    // Only the funct field of the instruction word matters here
    assign unused_instr_bits = ^instr[31:6];

    assign sc_hit        = instr_valid & syscall_en & (instr[5:0] == FUNCT_SYSCALL);
    assign is_print_int  = (v0 == DATA_W'(SYS_PRINT_INT));
    assign is_print_char = (v0 == DATA_W'(SYS_PRINT_CHAR));
    assign is_exit       = (v0 == DATA_W'(SYS_EXIT));
    assign is_exit2      = (v0 == DATA_W'(SYS_EXIT2));
    assign is_print      = is_print_int | is_print_char;
    assign is_exit_any   = is_exit | is_exit2;

    // A full FIFO stalls even if the head is being popped this same cycle;
    // the print is taken on the following cycle once space exists.
    assign stall       = (~in_run & instr_valid) | (sc_hit & is_print & fifo_full);
    assign retire      = instr_valid & ~stall & in_run;
    assign push        = retire & sc_hit & is_print;
    assign exit_retire = retire & sc_hit & is_exit_any;
    assign bad_retire  = retire & sc_hit & ~is_print & ~is_exit_any;

    assign push_kind    = is_print_char ? KIND_CHAR : KIND_INT;
    assign push_payload = is_print_char ? {{(DATA_W-8){1'b0}}, a0[7:0]} : a0;
    assign push_entry   = {push_kind, push_payload};

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign out_kind  = head_entry[ENTRY_W-1:DATA_W];
    assign out_data  = head_entry[DATA_W-1:0];

    syscall_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: DRAIN leaves for HALT once the queue has emptied
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (exit_retire) state_next = DRAIN;
            DRAIN:   if (fifo_empty)  state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_run = 1'b0;
        halted = 1'b0;
        case (state)
            RUN:     in_run = 1'b1;
            HALT:    halted = 1'b1;
            default: begin
                in_run = 1'b0;
                halted = 1'b0;
            end
        endcase
    end

    // Exit code is captured on the same edge that leaves RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_code   <= '0;
            bad_syscall <= 1'b0;
        end else begin
            if (exit_retire) begin
                exit_code <= is_exit2 ? a0 : '0;
            end
            if (bad_retire) begin
                bad_syscall <= 1'b1;
            end
        end
    end

    // Statistics counters stop at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (!halted && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (retire && (instr_count != '1)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit
// Self-checking bench for syscall_unit: a table of hand-derived vectors,
// directed multi-cycle sequences (backpressure, exit drain, halt timing,
// counter saturation, async reset) and randomized traffic, all compared
// against a queue-based behavioural model. A second instance with narrow
// counters shares the stimulus to exercise saturation.
module tb_syscall_unit;

    localparam int          DATA_W  = 32;
    localparam int          CNT_W   = 48;
    localparam int          SMALL_W = 4;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] SC      = 32'h0000_000C;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              syscall_en;
    logic [31:0]       instr;
    logic              instr_valid;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              out_ready;

    logic              stall;
    logic              out_valid;
    logic [1:0]        out_kind;
    logic [DATA_W-1:0] out_data;
    logic              halted;
    logic [DATA_W-1:0] exit_code;
    logic              bad_syscall;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instr_count;

    logic              s_stall;
    logic              s_out_valid;
    logic [1:0]        s_out_kind;
    logic [DATA_W-1:0] s_out_data;
    logic              s_halted;
    logic [DATA_W-1:0] s_exit_code;
    logic              s_bad_syscall;
    logic [SMALL_W-1:0] s_cycle_count;
    logic [SMALL_W-1:0] s_instr_count;

    always #5 clk = ~clk;

    syscall_unit #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .syscall_en  (syscall_en),
        .instr       (instr),
        .instr_valid (instr_valid),
        .v0          (v0),
        .a0          (a0),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_kind    (out_kind),
        .out_data    (out_data),
        .halted      (halted),
        .exit_code   (exit_code),
        .bad_syscall (bad_syscall),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    syscall_unit #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(SMALL_W)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .syscall_en  (syscall_en),
        .instr       (instr),
        .instr_valid (instr_valid),
        .v0          (v0),
        .a0          (a0),
        .stall       (s_stall),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_kind    (s_out_kind),
        .out_data    (s_out_data),
        .halted      (s_halted),
        .exit_code   (s_exit_code),
        .bad_syscall (s_bad_syscall),
        .cycle_count (s_cycle_count),
        .instr_count (s_instr_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: pending prints as a queue plus a few flags
    logic [DATA_W+1:0] mq[$];
    bit                m_exited;
    bit                m_halted;
    bit                m_bad;
    logic [DATA_W-1:0] m_exit_code;
    longint            m_cyc;
    longint            m_ins;
    logic              last_stall;

    typedef struct {
        logic        iv;
        logic        se;
        logic [31:0] ins;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        rdy;
        logic        exp_stall;
        logic        exp_valid;
        logic [1:0]  exp_kind;
        logic [31:0] exp_data;
        int          exp_ic;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic iv, logic se, logic [31:0] ins, logic [31:0] sv0,
                                logic [31:0] sa0, logic rdy, logic es, logic ev,
                                logic [1:0] ek, logic [31:0] ed, int eic);
        vec_t v;
        v.iv = iv; v.se = se; v.ins = ins; v.v0 = sv0; v.a0 = sa0; v.rdy = rdy;
        v.exp_stall = es; v.exp_valid = ev; v.exp_kind = ek; v.exp_data = ed; v.exp_ic = eic;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic modelReset();
        mq.delete();
        m_exited    = 0;
        m_halted    = 0;
        m_bad       = 0;
        m_exit_code = '0;
        m_cyc       = 0;
        m_ins       = 0;
    endtask

    task automatic checkModel();
        checkOutput("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            checkOutput("out_kind", out_kind, mq[0][DATA_W+1:DATA_W]);
            checkOutput("out_data", out_data, mq[0][DATA_W-1:0]);
        end
        checkOutput("halted", halted, m_halted);
        checkOutput("exit_code", exit_code, m_exit_code);
        checkOutput("bad_syscall", bad_syscall, m_bad);
        checkOutput("cycle_count", cycle_count, sat(m_cyc, CNT_W));
        checkOutput("instr_count", instr_count, sat(m_ins, CNT_W));
        checkOutput("small_cycle_count", s_cycle_count, sat(m_cyc, SMALL_W));
        checkOutput("small_instr_count", s_instr_count, sat(m_ins, SMALL_W));
    endtask

    // One clock cycle: drive at the falling edge, check stall, advance the
    // model across the rising edge, check registered outputs at the next fall
    task automatic applyStimulus(input logic i_iv, input logic i_se, input logic [31:0] i_ins,
                                 input logic [31:0] i_v0, input logic [31:0] i_a0,
                                 input logic i_rdy);
        bit hit, prt, ext, exp_stall, ret;
        instr_valid = i_iv;
        syscall_en  = i_se;
        instr       = i_ins;
        v0          = i_v0;
        a0          = i_a0;
        out_ready   = i_rdy;
        #1;
        hit       = i_iv && i_se && (i_ins[5:0] == 6'h0C);
        prt       = (i_v0 == 1) || (i_v0 == 11);
        ext       = (i_v0 == 10) || (i_v0 == 17);
        exp_stall = (m_exited && i_iv) || (hit && prt && mq.size() == DEPTH);
        last_stall = stall;
        checkOutput("stall", stall, exp_stall);
        ret = i_iv && !exp_stall && !m_exited;
        if (!m_halted) m_cyc++;
        if (m_exited && !m_halted && mq.size() == 0) m_halted = 1;
        if (mq.size() != 0 && i_rdy) void'(mq.pop_front());
        if (ret) begin
            m_ins++;
            if (hit && prt) begin
                if (i_v0 == 11) mq.push_back({2'd1, 24'd0, i_a0[7:0]});
                else            mq.push_back({2'd0, i_a0});
            end else if (hit && ext) begin
                m_exited    = 1;
                m_exit_code = (i_v0 == 17) ? i_a0 : '0;
            end else if (hit) begin
                m_bad = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    task automatic idle(input logic i_rdy);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, i_rdy);
    endtask

    // Entered and left at a falling edge; reset lands mid-cycle and outputs
    // are checked before any rising edge can occur
    task automatic doReset();
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkModel();
        checkOutput("rst_stall", stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r_v0;
        logic [5:0]  funct;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        syscall_en  = 1'b0;
        instr       = '0;
        v0          = '0;
        a0          = '0;
        out_ready   = 1'b0;
        modelReset();
        @(negedge clk);
        doReset();

        // Single print, then backpressure with a full FIFO and wrap-around
        vecs[0]  = mk(1, 1, SC, 1,  42,           1, 0, 1, 0, 42,    1);
        vecs[1]  = mk(0, 0, 0,  0,  0,            1, 0, 0, 0, 0,     1);
        vecs[2]  = mk(1, 1, SC, 1,  100,          0, 0, 1, 0, 100,   2);
        vecs[3]  = mk(1, 1, SC, 1,  101,          0, 0, 1, 0, 100,   3);
        vecs[4]  = mk(1, 1, SC, 1,  102,          0, 0, 1, 0, 100,   4);
        vecs[5]  = mk(1, 1, SC, 1,  103,          0, 0, 1, 0, 100,   5);
        vecs[6]  = mk(1, 1, SC, 11, 32'h12345641, 0, 1, 1, 0, 100,   5);
        vecs[7]  = mk(1, 1, SC, 11, 32'h12345641, 1, 1, 1, 0, 101,   5);
        vecs[8]  = mk(1, 1, SC, 11, 32'h12345641, 0, 0, 1, 0, 101,   6);
        vecs[9]  = mk(0, 0, 0,  0,  0,            1, 0, 1, 0, 102,   6);
        vecs[10] = mk(0, 0, 0,  0,  0,            1, 0, 1, 0, 103,   6);
        vecs[11] = mk(0, 0, 0,  0,  0,            1, 0, 1, 1, 32'h41, 6);
        vecs[12] = mk(0, 0, 0,  0,  0,            1, 0, 0, 0, 0,     6);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].se, vecs[i].ins, vecs[i].v0, vecs[i].a0, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_stall", i), last_stall, vecs[i].exp_stall);
            checkOutput($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_kind", i), out_kind, vecs[i].exp_kind);
                checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            end
            checkOutput($sformatf("vec%0d_icount", i), instr_count, 64'(vecs[i].exp_ic));
        end

        // Unsupported selector retires as a no-op and sets a sticky flag
        applyStimulus(1, 1, SC, 5, 32'hDEAD, 1);
        checkOutput("bad_set", bad_syscall, 1'b1);
        checkOutput("bad_nopush", out_valid, 1'b0);
        checkOutput("bad_icount", instr_count, 64'd7);
        idle(1);
        checkOutput("bad_sticky", bad_syscall, 1'b1);

        // Randomized traffic without exits
        for (int i = 0; i < 300; i++) begin
            funct = ($urandom_range(0, 4) != 0) ? 6'h0C : 6'($urandom_range(0, 63));
            case ($urandom_range(0, 5))
                0, 1:    r_v0 = 1;
                2, 3:    r_v0 = 11;
                4:       r_v0 = 0;
                default: r_v0 = $urandom_range(18, 1000);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                          {26'($urandom), funct}, r_v0, $urandom, $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 6; i++) idle(1);

        // Exit with code while prints are pending
        applyStimulus(1, 1, SC, 1, 11, 0);
        applyStimulus(1, 1, SC, 1, 12, 0);
        applyStimulus(1, 1, SC, 17, 7, 0);
        checkOutput("drain_not_halted", halted, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, SC, 1, 99, 0);
            checkOutput("drain_stall", last_stall, 1'b1);
            checkOutput("drain_halted", halted, 1'b0);
        end
        idle(1);
        idle(1);
        checkOutput("drain_last_pop_halted", halted, 1'b0);
        idle(1);
        checkOutput("drain_halted_set", halted, 1'b1);
        checkOutput("drain_exit_code", exit_code, 64'd7);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, SC, 1, 5, 1);

        // Plain exit with an empty FIFO
        doReset();
        applyStimulus(1, 1, SC, 10, 32'h55, 1);
        checkOutput("exit0_after_retire", halted, 1'b0);
        idle(1);
        checkOutput("exit0_halted", halted, 1'b1);
        checkOutput("exit0_code", exit_code, 64'd0);

        // Counter saturation on the narrow instance, then reset mid-drain
        doReset();
        for (int i = 0; i < 20; i++) idle(1);
        checkOutput("sat_small_cycle", s_cycle_count, 64'd15);
        checkOutput("sat_wide_cycle", cycle_count, 64'd20);
        applyStimulus(1, 1, SC, 1, 3, 0);
        applyStimulus(1, 1, SC, 10, 0, 0);
        idle(0);
        checkOutput("middrain_valid", out_valid, 1'b1);
        doReset();
        checkOutput("post_reset_valid", out_valid, 1'b0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
